systolic_mm_engine: RTL and testbench

SYSTOLIC_MM_ENGINE -- requirements
Module: systolic_mm_engine

---
 rtl/systolic_mm_engine.sv | 235 +++++++++++++++++++++++
 tb/tb_systolic_mm_engine.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mm_engine.sv
// Output-stationary ROWS x COLS systolic matrix-multiply engine: C = A(ROWS x K) * B(K x COLS).
// Define SYSTOLIC_SAT_EN to make accumulators saturate and drive a sticky sat_flag; otherwise they wrap.

module systolic_pe #(
    parameter int DW   = 8,
    parameter int ACCW = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   clr,
    input  logic signed [DW-1:0]   a,
    input  logic signed [DW-1:0]   b,
    output logic signed [ACCW-1:0] acc
`ifdef SYSTOLIC_SAT_EN
    ,
    output logic                   ovf
`endif
);
    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] prod_x, sum, acc_nxt;

    assign prod   = (2*DW)'(a) * (2*DW)'(b);
    assign prod_x = ACCW'(prod);
    assign sum    = acc + prod_x;

`ifdef SYSTOLIC_SAT_EN
    localparam logic signed [ACCW-1:0] SMAX = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SMIN = {1'b1, {(ACCW-1){1'b0}}};
    // Overflow only possible when both addends share a sign and the sum flips it.
    assign ovf     = en && (acc[ACCW-1] == prod_x[ACCW-1]) && (sum[ACCW-1] != acc[ACCW-1]);
    assign acc_nxt = !ovf ? sum : (acc[ACCW-1] ? SMIN : SMAX);
`else
    assign acc_nxt = sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   acc <= '0;
        else if (clr) acc <= '0;
        else if (en)  acc <= acc_nxt;
    end
endmodule

module systolic_mm_engine #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 8,
    parameter int ACCW = 32,
    parameter int KMAX = 256,
    localparam int KW  = $clog2(KMAX + 1),
    localparam int IW  = $clog2(ROWS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ROWS*DW-1:0]   a_col,
    input  logic [COLS*DW-1:0]   b_row,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IW-1:0]        out_idx,
    output logic [COLS*ACCW-1:0] out_data,
    output logic                 busy,
    output logic                 done,
    output logic                 sat_flag
);
    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;

    localparam int            FW         = $clog2(ROWS + COLS - 2);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(ROWS + COLS - 3);

    state_t        state, state_nxt;
    logic [KW-1:0] k_eff, k_reg, beat_cnt;
    logic [FW-1:0] flush_cnt;
    logic          take_start, accept, last_beat, flush_end, row_take, last_row, en;

    assign k_eff      = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;
    assign take_start = (state == IDLE) && start;
    assign accept     = in_valid && in_ready;
    assign last_beat  = accept && ((beat_cnt + KW'(1)) == k_reg);
    assign flush_end  = (state == FLUSH) && (flush_cnt == FLUSH_LAST);
    assign row_take   = out_valid && out_ready;
    assign last_row   = row_take && (out_idx == IW'(ROWS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (k_eff == '0) ? DRAIN : FEED;
            FEED:    if (last_beat) state_nxt = FLUSH;
            FLUSH:   if (flush_end) state_nxt = DRAIN;
            DRAIN:   if (last_row) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        en        = 1'b0;
        case (state)
            FEED:    begin in_ready = 1'b1; en = in_valid; end
            FLUSH:   en = 1'b1;
            DRAIN:   out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg     <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            out_idx   <= '0;
            done      <= 1'b0;
        end else begin
            done <= last_row;
            if (take_start) begin
                k_reg    <= k_eff;
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + KW'(1);
            end
            flush_cnt <= (state == FLUSH) ? flush_cnt + FW'(1) : '0;
            if (row_take) out_idx <= last_row ? '0 : out_idx + IW'(1);
        end
    end

    // Zero operands outside FEED so FLUSH pushes bubbles through the array.
    logic [ROWS-1:0][DW-1:0] a_vec, a_edge;
    logic [COLS-1:0][DW-1:0] b_vec, b_edge;
    assign a_vec = (state == FEED) ? a_col : '0;
    assign b_vec = (state == FEED) ? b_row : '0;

    for (genvar r = 0; r < ROWS; r++) begin : g_askew
        if (r == 0) begin : g_direct
            assign a_edge[r] = a_vec[r];
        end else begin : g_delay
            logic [r-1:0][DW-1:0] sr;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)          sr <= '0;
                else if (take_start) sr <= '0;
                else if (en) begin
                    sr[0] <= a_vec[r];
                    for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
                end
            end
            assign a_edge[r] = sr[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_bskew
        if (c == 0) begin : g_direct
            assign b_edge[c] = b_vec[c];
        end else begin : g_delay
            logic [c-1:0][DW-1:0] sr;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)          sr <= '0;
                else if (take_start) sr <= '0;
                else if (en) begin
                    sr[0] <= b_vec[c];
                    for (int i = 1; i < c; i++) sr[i] <= sr[i-1];
                end
            end
            assign b_edge[c] = sr[c-1];
        end
    end

    logic [ROWS-1:0][COLS-1:0][DW-1:0]   a_w, b_w;
    logic [ROWS-1:0][COLS-1:0][ACCW-1:0] acc;
`ifdef SYSTOLIC_SAT_EN
    logic [ROWS-1:0][COLS-1:0]           ovf;
`endif

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            if (c == 0) begin : g_aedge
                assign a_w[r][c] = a_edge[r];
            end else begin : g_ahop
                logic [DW-1:0] q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)          q <= '0;
                    else if (take_start) q <= '0;
                    else if (en)         q <= a_w[r][c-1];
                end
                assign a_w[r][c] = q;
            end

            if (r == 0) begin : g_bedge
                assign b_w[r][c] = b_edge[c];
            end else begin : g_bhop
                logic [DW-1:0] q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)          q <= '0;
                    else if (take_start) q <= '0;
                    else if (en)         q <= b_w[r-1][c];
                end
                assign b_w[r][c] = q;
            end

            systolic_pe #(.DW(DW), .ACCW(ACCW)) u_pe (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .clr   (take_start),
                .a     (a_w[r][c]),
                .b     (b_w[r][c]),
                .acc   (acc[r][c])
`ifdef SYSTOLIC_SAT_EN
                ,
                .ovf   (ovf[r][c])
`endif
            );
        end
    end

    assign out_data = out_valid ? acc[out_idx] : '0;

`ifdef SYSTOLIC_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          sat_flag <= 1'b0;
        else if (take_start) sat_flag <= 1'b0;
        else if (|ovf)       sat_flag <= 1'b1;
    end
`else
    assign sat_flag = 1'b0;
`endif
endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench for systolic_mm_engine: a 4x4/ACCW=32 instance plus a 4x4/ACCW=16/KMAX=4 instance for overflow.
module tb_systolic_mm_engine;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start, in_valid, in_ready, out_valid, out_ready, busy, done, sat_flag;
    logic [8:0]   k_len;
    logic [31:0]  a_col, b_row;
    logic [1:0]   out_idx;
    logic [127:0] out_data;

    logic         d2_start, d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready, d2_busy, d2_done, d2_sat;
    logic [2:0]   d2_k;
    logic [31:0]  d2_a, d2_b;
    logic [1:0]   d2_idx;
    logic [63:0]  d2_data;

    int           checks = 0;
    int           errs = 0;
    logic [127:0] exp_row [4];

    always #5 clk = ~clk;

    systolic_mm_engine #(.ROWS(4), .COLS(4), .DW(8), .ACCW(32), .KMAX(256)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data),
        .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    systolic_mm_engine #(.ROWS(4), .COLS(4), .DW(8), .ACCW(16), .KMAX(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(d2_start), .k_len(d2_k),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready), .a_col(d2_a), .b_row(d2_b),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_idx(d2_idx), .out_data(d2_data),
        .busy(d2_busy), .done(d2_done), .sat_flag(d2_sat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic feed(input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        a_col    = a;
        b_row    = b;
        tick();
    endtask

    task automatic wait_ov(output int n);
        n = 0;
        while (!out_valid && n < 64) begin
            tick();
            n++;
        end
    endtask

    task automatic drain_all(input string tag);
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("%s_valid%0d", tag, r), out_valid, 1);
            chk($sformatf("%s_idx%0d", tag, r), out_idx, r);
            chk($sformatf("%s_row%0d", tag, r), out_data, exp_row[r]);
            chk($sformatf("%s_rdy%0d", tag, r), in_ready, 0);
            tick();
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        tick();
        chk({tag, "_done_clr"}, done, 0);
    endtask

    function automatic logic [31:0] id_col(input int k);
        logic [31:0] v;
        v = 32'h1 << (8 * k);
        return v;
    endfunction

    function automatic logic [31:0] b_of(input int k);
        return {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
    endfunction

    task automatic load_b_exp();
        for (int r = 0; r < 4; r++)
            exp_row[r] = {32'(4*r+3), 32'(4*r+2), 32'(4*r+1), 32'(4*r)};
    endtask

    task automatic fill_exp(input logic [31:0] v);
        for (int r = 0; r < 4; r++) exp_row[r] = {4{v}};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, fc, beats;
        logic [15:0] e16;
        logic        esat;

        start = 0; k_len = 0; in_valid = 0; a_col = 0; b_row = 0; out_ready = 1;
        d2_start = 0; d2_k = 0; d2_in_valid = 0; d2_a = 0; d2_b = 0; d2_out_ready = 1;
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sat", sat_flag, 0);
        rst_n = 1;
        tick();
        chk("idle_busy", busy, 0);

        // Identity A, B[k][c] = 4k+c, no stalls
        start = 1; k_len = 4; tick(); start = 0;
        chk("t1_busy", busy, 1);
        chk("t1_in_ready", in_ready, 1);
        for (int k = 0; k < 4; k++) feed(id_col(k), b_of(k));
        in_valid = 0;
        chk("t1_flush_rdy", in_ready, 0);
        wait_ov(n);
        chk("t1_latency", 5 + n, 11);
        load_b_exp();
        drain_all("t1");

        // All -128, K=3, no stalls
        start = 1; k_len = 3; tick(); start = 0;
        for (int k = 0; k < 3; k++) feed(32'h80808080, 32'h80808080);
        in_valid = 0;
        wait_ov(n);
        chk("t2_latency", 4 + n, 10);
        fill_exp(32'd49152);
        drain_all("t2");

        // Same with in_valid toggling 0/1; bubbles carry junk that must be ignored
        start = 1; k_len = 3; tick(); start = 0;
        fc = 0;
        while (in_ready && fc < 20) begin
            in_valid = fc[0];
            a_col    = in_valid ? 32'h80808080 : 32'h55555555;
            b_row    = in_valid ? 32'h80808080 : 32'h3C3C3C3C;
            fc++;
            tick();
        end
        in_valid = 0;
        chk("t2b_feed_cycles", fc, 6);
        wait_ov(n);
        drain_all("t2b");

        // K=0: straight to DRAIN with zero rows, in_valid ignored
        start = 1; k_len = 0; in_valid = 1; a_col = 32'h01010101; b_row = 32'h01010101;
        tick(); start = 0;
        chk("t3_drain_now", out_valid, 1);
        fill_exp(32'd0);
        drain_all("t3");
        in_valid = 0;

        // Backpressure on row 2
        start = 1; k_len = 4; tick(); start = 0;
        for (int k = 0; k < 4; k++) feed(id_col(k), b_of(k));
        in_valid = 0;
        wait_ov(n);
        load_b_exp();
        out_ready = 1;
        tick(); tick();
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_idx", out_idx, 2);
            chk("t4_hold_data", out_data, exp_row[2]);
            chk("t4_hold_valid", out_valid, 1);
            tick();
        end
        out_ready = 1;
        chk("t4_row2", out_data, exp_row[2]);
        tick();
        chk("t4_idx3", out_idx, 3);
        chk("t4_row3", out_data, exp_row[3]);
        tick();
        chk("t4_done", done, 1);
        tick();

        // Reset during FLUSH, then a fresh K=2 product of all ones
        start = 1; k_len = 4; tick(); start = 0;
        for (int k = 0; k < 4; k++) feed(id_col(k), b_of(k));
        in_valid = 0;
        tick(); tick();
        chk("t5_flush_busy", busy, 1);
        #1 rst_n = 0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_ready", in_ready, 0);
        chk("t5_rst_idx", out_idx, 0);
        chk("t5_rst_data", out_data, 0);
        chk("t5_rst_done", done, 0);
        rst_n = 1;
        tick();
        chk("t5_no_done", done, 0);
        chk("t5_idle", busy, 0);
        start = 1; k_len = 2; tick(); start = 0;
        for (int k = 0; k < 2; k++) feed(32'h01010101, 32'h01010101);
        in_valid = 0;
        wait_ov(n);
        chk("t5_latency", 3 + n, 9);
        fill_exp(32'd2);
        drain_all("t5");

        // ACCW=16 overflow; k_len=7 clamps to KMAX=4
`ifdef SYSTOLIC_SAT_EN
        e16 = 16'h7FFF; esat = 1'b1;
`else
        e16 = 16'hFC04; esat = 1'b0;
`endif
        d2_start = 1; d2_k = 3'd7; tick(); d2_start = 0;
        beats = 0;
        while (d2_in_ready && beats < 10) begin
            d2_in_valid = 1; d2_a = 32'h7F7F7F7F; d2_b = 32'h7F7F7F7F;
            tick();
            beats++;
        end
        d2_in_valid = 0;
        chk("t6_clamp_beats", beats, 4);
        n = 0;
        while (!d2_out_valid && n < 64) begin tick(); n++; end
        chk("t6_valid", d2_out_valid, 1);
        chk("t6_sat", d2_sat, esat);
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("t6_row%0d", r), d2_data, {4{e16}});
            tick();
        end
        chk("t6_done", d2_done, 1);
        d2_start = 1; d2_k = 3'd0; tick(); d2_start = 0;
        chk("t6_sat_clr", d2_sat, 0);
        chk("t6_zero_row", d2_data, 0);
        repeat (4) tick();
        chk("t6_zero_done", d2_done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end
endmodule
